// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the priority-encoder family.
package prio_enc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    NONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;

  // Index width for a given request width (at least one bit).
  function automatic int unsigned idx_width(input int unsigned width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/prio_enc_scanner_if.sv
// Request-in / index-out handshake bundle for prio_enc_scanner.
interface prio_enc_scanner_if
  import prio_enc_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  localparam int unsigned IDXW = idx_width(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             out_none;

  // Scanner side.
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none
  );

  // Request source / consumer side.
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none
  );
endinterface

// File: rtl/prio_enc_comb.sv
// Combinational priority encoder: index of the highest (or lowest) set bit.
module prio_enc_comb
  import prio_enc_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic [WIDTH-1:0]            vec,
  output logic [idx_width(WIDTH)-1:0] idx,
  output logic                        found
);
  localparam int unsigned IDXW = idx_width(WIDTH);

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec[LSB_FIRST ? (WIDTH - 1 - i) : i]) begin
        idx   = IDXW'(LSB_FIRST ? (WIDTH - 1 - i) : i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/prio_enc_scanner.sv
// Sequential priority scanner: emits the index of every set bit of an
// accepted request vector, one per output handshake, in priority order.
module prio_enc_scanner
  import prio_enc_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          LSB_FIRST = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  prio_enc_scanner_if.slave bus
);
  localparam int unsigned IDXW = idx_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [IDXW-1:0]  out_idx_q;
  logic             out_last_q;
  logic             out_none_q;

  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] pend_after;
  logic [WIDTH-1:0] enc_in;
  logic [IDXW-1:0]  enc_idx;
  logic             enc_found;
  logic             enc_single;

  // Outputs are registered; the encoder looks one step ahead (the incoming
  // vector in IDLE, the pending set minus the current beat in EMIT) so the
  // next beat's index/last are ready at the same edge that consumes this one.
  always_comb begin
    clr_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      clr_mask[i] = (IDXW'(i) == out_idx_q);
    end
    pend_after = pending & ~clr_mask;
    enc_in     = (state == IDLE) ? bus.in_vec : pend_after;
    enc_single = (enc_in != '0) && ((enc_in & (enc_in - WIDTH'(1))) == '0);
  end

  prio_enc_comb #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_enc (
    .vec   (enc_in),
    .idx   (enc_idx),
    .found (enc_found)
  );

  // Scan FSM: reset, then flush, then handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pending     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_none_q  <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      pending     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_none_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            pending     <= bus.in_vec;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            if (enc_found) begin
              state      <= EMIT;
              out_idx_q  <= enc_idx;
              out_last_q <= enc_single;
              out_none_q <= 1'b0;
            end else begin
              state      <= NONE;
              out_idx_q  <= '0;
              out_last_q <= 1'b1;
              out_none_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            pending <= pend_after;
            if (out_last_q) begin
              state       <= IDLE;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_idx_q   <= '0;
              out_last_q  <= 1'b0;
            end else begin
              out_idx_q  <= enc_idx;
              out_last_q <= enc_single;
            end
          end
        end
        NONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_none_q  <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          pending     <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_idx_q   <= '0;
          out_last_q  <= 1'b0;
          out_none_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_none  = out_none_q;
endmodule

// File: tb/tb_prio_enc_scanner.sv
// Scoreboard bench: three scanners (8-bit MSB-first, 8-bit LSB-first,
// 12-bit MSB-first) driven in lockstep with equal set-bit counts.
module tb_prio_enc_scanner;
  import prio_enc_pkg::*;

  typedef struct packed {
    logic [3:0] idx;
    logic       last;
    logic       none;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  vec8 = '0;
  logic [11:0] vec12 = '0;

  always #5 clk = ~clk;

  prio_enc_scanner_if #(.WIDTH(8))  b8m ();
  prio_enc_scanner_if #(.WIDTH(8))  b8l ();
  prio_enc_scanner_if #(.WIDTH(12)) b12 ();

  assign b8m.in_valid  = in_valid;
  assign b8m.in_vec    = vec8;
  assign b8m.out_ready = out_ready;
  assign b8l.in_valid  = in_valid;
  assign b8l.in_vec    = vec8;
  assign b8l.out_ready = out_ready;
  assign b12.in_valid  = in_valid;
  assign b12.in_vec    = vec12;
  assign b12.out_ready = out_ready;

  prio_enc_scanner #(.WIDTH(8), .LSB_FIRST(1'b0)) u_m8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b8m));
  prio_enc_scanner #(.WIDTH(8), .LSB_FIRST(1'b1)) u_l8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b8l));
  prio_enc_scanner #(.WIDTH(12), .LSB_FIRST(1'b0)) u_w12 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b12));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  beat_t q0[$];
  beat_t q1[$];
  beat_t q2[$];

  task automatic qpush(input int k, input beat_t b);
    case (k)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpop(input int k, output beat_t b);
    case (k)
      0: b = q0.pop_front();
      1: b = q1.pop_front();
      default: b = q2.pop_front();
    endcase
  endtask

  task automatic qclear();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  // Reference model: expected beats for one accepted vector.
  task automatic push_beats(input int k, input int w, input bit lsb, input logic [11:0] v);
    beat_t b;
    int cnt;
    int seen;
    int bitn;
    if (v == '0) begin
      b.idx = 4'd0; b.last = 1'b1; b.none = 1'b1;
      qpush(k, b);
    end else begin
      cnt = 0;
      for (int i = 0; i < w; i++) if (v[i]) cnt++;
      seen = 0;
      for (int i = 0; i < w; i++) begin
        bitn = lsb ? i : (w - 1 - i);
        if (v[bitn]) begin
          seen++;
          b.idx = 4'(bitn); b.last = (seen == cnt); b.none = 1'b0;
          qpush(k, b);
        end
      end
    end
  endtask

  beat_t held[3];
  bit    holding[3];
  bit    after_last[3];

  task automatic mon(input int k, input string nm, input logic v, input logic r,
                     input logic [3:0] idx, input logic last, input logic none,
                     input logic iready, input int maxidx);
    beat_t e;
    if (after_last[k]) begin
      check({nm, "_ready_after_last"}, iready, 1);
      check({nm, "_valid_after_last"}, v, 0);
    end
    if (holding[k] && v) begin
      check({nm, "_hold_idx"}, idx, held[k].idx);
      check({nm, "_hold_last"}, last, held[k].last);
      check({nm, "_hold_none"}, none, held[k].none);
    end
    if (!v) check({nm, "_idle_zero"}, {idx, last, none}, 0);
    else    check({nm, "_idx_range"}, (int'(idx) <= maxidx), 1);
    after_last[k] = 1'b0;
    holding[k]    = 1'b0;
    if (rst_n && !flush && v) begin
      if (r) begin
        if (qsize(k) == 0) begin
          check({nm, "_unexpected_beat"}, 1, 0);
        end else begin
          qpop(k, e);
          check({nm, "_idx"}, idx, e.idx);
          check({nm, "_last"}, last, e.last);
          check({nm, "_none"}, none, e.none);
          after_last[k] = last;
        end
      end else begin
        holding[k]   = 1'b1;
        held[k].idx  = idx;
        held[k].last = last;
        held[k].none = none;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, "m8", b8m.out_valid, out_ready, 4'(b8m.out_idx), b8m.out_last, b8m.out_none, b8m.in_ready, 7);
    mon(1, "l8", b8l.out_valid, out_ready, 4'(b8l.out_idx), b8l.out_last, b8l.out_none, b8l.in_ready, 7);
    mon(2, "w12", b12.out_valid, out_ready, b12.out_idx, b12.out_last, b12.out_none, b12.in_ready, 11);
  end

  function automatic logic all_ready();
    return b8m.in_ready && b8l.in_ready && b12.in_ready;
  endfunction

  // Called from posedge+#1 context; returns at posedge+#1 after acceptance.
  task automatic send(input logic [7:0] v8, input logic [11:0] v12);
    int t = 0;
    while (!all_ready() && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) check("send_timeout", 0, 1);
    in_valid = 1'b1; vec8 = v8; vec12 = v12;
    @(posedge clk); #1;
    in_valid = 1'b0;
    push_beats(0, 8, 1'b0, {4'h0, v8});
    push_beats(1, 8, 1'b1, {4'h0, v8});
    push_beats(2, 12, 1'b0, v12);
  endtask

  task automatic drain(input bit rnd);
    int t = 0;
    while ((qsize(0) != 0 || qsize(1) != 0 || qsize(2) != 0 || !all_ready()) && t < 400) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; t++;
    end
    if (t >= 400) check("drain_timeout", 0, 1);
    out_ready = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_m8_ready"}, b8m.in_ready, 1);
    check({tag, "_m8_valid"}, b8m.out_valid, 0);
    check({tag, "_l8_ready"}, b8l.in_ready, 1);
    check({tag, "_w12_ready"}, b12.in_ready, 1);
    check({tag, "_w12_valid"}, b12.out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rv;
    rst_n = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_m8_idx", {b8m.out_idx, b8m.out_last, b8m.out_none}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("post_reset");

    // Mixed vector, free-flowing consumer.
    send(8'hA5, 12'h0A5); drain(1'b0);
    // All-zero vector.
    send(8'h00, 12'h000); drain(1'b0);

    // Backpressure, with an ignored offer while busy.
    out_ready = 1'b0;
    send(8'h88, 12'h088);
    in_valid = 1'b1; vec8 = 8'hFF; vec12 = 12'hFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    drain(1'b0);

    // Flush after the first beat.
    out_ready = 1'b1;
    send(8'hFF, 12'h0FF);
    @(posedge clk); #1;
    flush = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; qclear();
    check_idle("flush");
    out_ready = 1'b1;
    send(8'h01, 12'h001); drain(1'b0);

    // Same with reset instead of flush.
    send(8'hFF, 12'h0FF);
    @(posedge clk); #1;
    rst_n = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; qclear();
    check_idle("rst_mid");
    out_ready = 1'b1;
    send(8'h01, 12'h001); drain(1'b0);

    // Non-power-of-2 width top bit.
    send(8'h88, 12'h808); drain(1'b0);

    // Random vectors with a random consumer.
    repeat (20) begin
      rv = 8'($urandom);
      send(rv, {4'h0, rv});
      drain(1'b1);
    end

    check("queue_empty", qsize(0) + qsize(1) + qsize(2), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
